// File: rtl/ym_dbg_pkg.sv
// ym_dbg_pkg: shared state encoding and width helper for the debug-readout capture path.
package ym_dbg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Never returns less than 1 so single-entry fields stay legal vectors.
    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v >>= 1) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ym_dbg_capture_if.sv
// ym_dbg_capture_if: chain inputs, output word stream and status of the capture block.
interface ym_dbg_capture_if #(
    parameter int WORD_WIDTH = 16,
    parameter int WORDS      = 4
);
    localparam int IW = ym_dbg_pkg::clog2(WORDS);

    logic                  c1;
    logic                  c2;
    logic                  load;
    logic                  sdata;
    logic [WORD_WIDTH-1:0] out_data;
    logic [IW-1:0]         out_index;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  ovf_clr;
    logic                  overflow;
    logic                  frame_abort;
    logic                  busy;

    modport slave (
        input  c1, c2, load, sdata, out_ready, ovf_clr,
        output out_data, out_index, out_last, out_valid, overflow, frame_abort, busy
    );

    modport master (
        output c1, c2, load, sdata, out_ready, ovf_clr,
        input  out_data, out_index, out_last, out_valid, overflow, frame_abort, busy
    );
endinterface

// File: rtl/ym_dbg_fifo.sv
// ym_dbg_fifo: synchronous FIFO; a push while full is accepted only alongside a pop.
module ym_dbg_fifo
    import ym_dbg_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             MCLK,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge MCLK) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/ym_dbg_capture.sv
// ym_dbg_capture: deserialises the LSB-first debug chain stream into indexed words
// and queues them on a valid/ready port.
module ym_dbg_capture
    import ym_dbg_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int WORDS      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic               MCLK,
    input logic               rst,
    ym_dbg_capture_if.slave   bus
);
    localparam int BW = clog2(WORD_WIDTH);
    localparam int IW = clog2(WORDS);
    localparam int FW = WORD_WIDTH + IW + 1;

    state_t                state_q;
    logic                  c1_q, abort_q, ovf_q;
    logic [BW-1:0]         bitcnt_q;
    logic [IW-1:0]         wordcnt_q;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tick, shifting, push, pop, full, empty, last_word;
    logic [FW-1:0]         head;
    logic                  unused_ok;

    assign unused_ok = ^{bus.c2, shreg_q[0]};
    assign tick      = bus.c1 && !c1_q;
    assign shifting  = state_q == SHIFT && tick && !bus.load;
    assign shreg_d   = {bus.sdata, shreg_q[WORD_WIDTH-1:1]};
    assign last_word = wordcnt_q == IW'(WORDS - 1);
    assign push      = shifting && bitcnt_q == BW'(WORD_WIDTH - 1);
    assign pop       = !empty && bus.out_ready;

    ym_dbg_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .MCLK  (MCLK),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({shreg_d, wordcnt_q, last_word}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign {bus.out_data, bus.out_index, bus.out_last} = head;
    assign bus.out_valid   = !empty;
    assign bus.overflow    = ovf_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = state_q == SHIFT;

    always_ff @(posedge MCLK) begin
        if (!rst) begin
            state_q   <= IDLE;
            c1_q      <= 1'b0;
            abort_q   <= 1'b0;
            ovf_q     <= 1'b0;
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            c1_q    <= bus.c1;
            abort_q <= state_q == SHIFT && tick && bus.load;
            // A drop in the same cycle as a clear wins.
            ovf_q   <= (push && full && !pop) || (ovf_q && !bus.ovf_clr);
            if (tick && bus.load) begin
                state_q   <= SHIFT;
                bitcnt_q  <= '0;
                wordcnt_q <= '0;
            end else if (shifting) begin
                shreg_q  <= shreg_d;
                bitcnt_q <= push ? '0 : bitcnt_q + 1'b1;
                if (push) begin
                    wordcnt_q <= last_word ? '0 : wordcnt_q + 1'b1;
                    if (last_word) state_q <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_ym_dbg_capture.sv
// tb_ym_dbg_capture: directed scenarios for the debug-chain capture block.
module tb_ym_dbg_capture;
    logic MCLK = 1'b0;
    logic rst  = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [15:0] q_data [$];
    logic [1:0]  q_idx  [$];
    logic        q_last [$];
    logic [15:0] exp_w  [4];

    ym_dbg_capture_if #(.WORD_WIDTH(16), .WORDS(4)) ifc ();

    ym_dbg_capture #(.WORD_WIDTH(16), .WORDS(4), .FIFO_DEPTH(4)) dut (
        .MCLK (MCLK),
        .rst  (rst),
        .bus  (ifc.slave)
    );

    always #5 MCLK = ~MCLK;

    always @(negedge MCLK)
        if (rst && ifc.out_valid && ifc.out_ready) begin
            q_data.push_back(ifc.out_data);
            q_idx.push_back(ifc.out_index);
            q_last.push_back(ifc.out_last);
        end

    task automatic cyc(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic phase(input logic ld, input logic sd, input int hold);
        ifc.c1 = 1'b1; ifc.c2 = 1'b0; ifc.load = ld; ifc.sdata = sd;
        cyc(hold);
        ifc.c1 = 1'b0; ifc.c2 = 1'b1; ifc.load = 1'b0;
        cyc(hold);
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits, input int hold);
        for (int b = 0; b < nbits; b++) phase(1'b0, w[b], hold);
    endtask

    task automatic clear_q();
        q_data.delete(); q_idx.delete(); q_last.delete();
    endtask

    task automatic check_frame(input string name);
        n_chk++;
        if (q_data.size() !== 4) begin
            n_fail++;
            $display("FAIL %s count: got %0d words, expected 4", name, q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_chk++;
            if (q_data[i] !== exp_w[i] || q_idx[i] !== 2'(i) || q_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL %s word%0d: got %h/%0d/%b, expected %h/%0d/%b", name, i,
                         q_data[i], q_idx[i], q_last[i], exp_w[i], i, i == 3);
            end
        end
    endtask

    task automatic send_frame(input int hold);
        phase(1'b1, 1'b0, hold);
        for (int i = 0; i < 4; i++) send_bits(exp_w[i], 16, hold);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.c1 = 1'($urandom); ifc.c2 = 1'($urandom); ifc.load = 1'($urandom);
            ifc.sdata = 1'($urandom); ifc.out_ready = 1'($urandom); ifc.ovf_clr = 1'($urandom);
            cyc(1);
        end
        n_chk++;
        if ({ifc.out_valid, ifc.overflow, ifc.busy, ifc.frame_abort} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset flags: got v/o/b/a=%b, expected 0000",
                     {ifc.out_valid, ifc.overflow, ifc.busy, ifc.frame_abort});
        end
        n_chk++;
        if (ifc.out_data !== 16'h0 || ifc.out_index !== 2'd0 || ifc.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset head: got %h/%0d/%b, expected 0000/0/0",
                     ifc.out_data, ifc.out_index, ifc.out_last);
        end
        ifc.c1 = 0; ifc.c2 = 0; ifc.load = 0; ifc.sdata = 0; ifc.out_ready = 0; ifc.ovf_clr = 0;
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_frame(input int hold, input string name);
        clear_q();
        ifc.out_ready = 1'b1;
        phase(1'b1, 1'b0, hold);
        n_chk++;
        if (ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after load: got %b, expected 1", name, ifc.busy);
        end
        for (int i = 0; i < 4; i++) send_bits(exp_w[i], 16, hold);
        cyc(3);
        check_frame(name);
        n_chk++;
        if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after frame: got busy=%b valid=%b, expected 0/0",
                     name, ifc.busy, ifc.out_valid);
        end
    endtask

    task automatic test_overflow();
        clear_q();
        ifc.out_ready = 1'b0;
        send_frame(1);
        n_chk++;
        if (ifc.overflow !== 1'b0 || ifc.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf full: got overflow=%b valid=%b, expected 0/1",
                     ifc.overflow, ifc.out_valid);
        end
        phase(1'b1, 1'b0, 1);
        send_bits(exp_w[0], 16, 1);
        n_chk++;
        if (ifc.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf fifth push: got overflow=%b, expected 1", ifc.overflow);
        end
        for (int i = 1; i < 4; i++) send_bits(exp_w[i], 16, 1);
        n_chk++;
        if (ifc.out_data !== 16'h1234 || ifc.out_index !== 2'd0) begin
            n_fail++;
            $display("FAIL ovf head stable: got %h/%0d, expected 1234/0",
                     ifc.out_data, ifc.out_index);
        end
        ifc.out_ready = 1'b1;
        cyc(6);
        check_frame("ovf drain");
        n_chk++;
        if (ifc.overflow !== 1'b1 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf after drain: got overflow=%b valid=%b, expected 1/0",
                     ifc.overflow, ifc.out_valid);
        end
        ifc.ovf_clr = 1'b1;
        cyc(1);
        ifc.ovf_clr = 1'b0;
        n_chk++;
        if (ifc.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf clear: got overflow=%b, expected 0", ifc.overflow);
        end
    endtask

    task automatic test_abort();
        clear_q();
        ifc.out_ready = 1'b1;
        phase(1'b1, 1'b0, 1);
        send_bits(16'h1234, 7, 1);
        ifc.c1 = 1'b1; ifc.load = 1'b1; ifc.sdata = 1'b1;
        cyc(1);
        n_chk++;
        if (ifc.frame_abort !== 1'b1) begin
            n_fail++;
            $display("FAIL abort pulse: got %b, expected 1", ifc.frame_abort);
        end
        ifc.c1 = 1'b0; ifc.load = 1'b0;
        cyc(1);
        n_chk++;
        if (ifc.frame_abort !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort after: got abort=%b valid=%b busy=%b, expected 0/0/1",
                     ifc.frame_abort, ifc.out_valid, ifc.busy);
        end
        send_bits(16'hABCD, 16, 1);
        cyc(2);
        n_chk++;
        if (q_data.size() !== 1 || q_data[0] !== 16'hABCD || q_idx[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL abort restart: got n=%0d %h/%0d, expected n=1 abcd/0",
                     q_data.size(), q_data[0], q_idx[0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        ifc.out_ready = 1'b0;
        phase(1'b1, 1'b0, 1);
        send_bits(exp_w[0], 16, 1);
        send_bits(exp_w[1], 16, 1);
        send_bits(exp_w[2], 5, 1);
        n_chk++;
        if (ifc.out_valid !== 1'b1 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst before: got valid=%b busy=%b, expected 1/1",
                     ifc.out_valid, ifc.busy);
        end
        rst = 1'b0;
        cyc(1);
        n_chk++;
        if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst after: got valid=%b busy=%b, expected 0/0",
                     ifc.out_valid, ifc.busy);
        end
        rst = 1'b1;
        cyc(1);
        test_frame(1, "post-reset frame");
    endtask

    initial begin
        exp_w = '{16'h1234, 16'hABCD, 16'h0001, 16'h8000};
        test_reset();
        test_frame(1, "frame");
        test_frame(3, "slow c1 frame");
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
